// File: rtl/rgbw_spi_frame_tx_if.sv
// rgbw_spi_frame_tx_if: frame request, configuration bytes, status and SPI pins of the lamp frame transmitter
interface rgbw_spi_frame_tx_if;
    logic       start;
    logic [7:0] mode_in;
    logic [7:0] lint_in;
    logic [7:0] color_idx_in;
    logic [7:0] red_in;
    logic [7:0] green_in;
    logic [7:0] blue_in;
    logic [7:0] white_in;
    logic       busy;
    logic       done;
    logic       sck;
    logic       cs;
    logic       mosi;

    modport master (
        output start, mode_in, lint_in, color_idx_in, red_in, green_in, blue_in, white_in,
        input  busy, done, sck, cs, mosi
    );

    modport slave (
        input  start, mode_in, lint_in, color_idx_in, red_in, green_in, blue_in, white_in,
        output busy, done, sck, cs, mosi
    );
endinterface

// File: rtl/rgbw_spi_frame_tx.sv
// rgbw_spi_frame_tx: SPI mode-0 master sending a 7-byte lamp configuration frame, MSB first, in one cs-low window
module rgbw_spi_frame_tx #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input logic             clk,
    input logic             reset,
    rgbw_spi_frame_tx_if.slave io
);
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [5:0]  bits, bits_n;
    logic [55:0] sr, sr_n;
    logic        sck, sck_n, cs, cs_n, busy, busy_n, done, done_n;
    logic        div_end;

    assign div_end = cnt == DIV_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            sr    <= '0;
            sck   <= 1'b0;
            cs    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bits  <= bits_n;
            sr    <= sr_n;
            sck   <= sck_n;
            cs    <= cs_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // The final shift empties the register, so mosi returns low without a separate data register.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        bits_n  = bits;
        sr_n    = sr;
        sck_n   = sck;
        cs_n    = cs;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (io.start) begin
                    sr_n    = {io.mode_in, io.lint_in, io.color_idx_in, io.red_in,
                               io.green_in, io.blue_in, io.white_in};
                    bits_n  = '0;
                    cs_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP, SCK_LO: if (div_end) begin
                cnt_n   = '0;
                sck_n   = 1'b1;
                state_n = SCK_HI;
            end
            SCK_HI: if (div_end) begin
                cnt_n   = '0;
                sck_n   = 1'b0;
                sr_n    = {sr[54:0], 1'b0};
                bits_n  = (bits == 6'd55) ? 6'd0 : bits + 6'd1;
                state_n = (bits == 6'd55) ? HOLD : SCK_LO;
            end
            HOLD: if (div_end) begin
                cnt_n   = '0;
                cs_n    = 1'b1;
                state_n = GAP;
            end
            GAP: if (cnt == GAP_LAST) begin
                cnt_n   = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign io.sck  = sck;
    assign io.cs   = cs;
    assign io.mosi = sr[55];
    assign io.busy = busy;
    assign io.done = done;
endmodule

// File: tb/tb_rgbw_spi_frame_tx.sv
// tb_rgbw_spi_frame_tx: directed frames on two transmitters (CLK_DIV 2 and 1) checked cycle-by-cycle against a timeline model
module tb_rgbw_spi_frame_tx;
    localparam int G = 4;
    localparam logic [55:0] FA = 56'h01FF00A55A3C81;
    localparam logic [55:0] FB = 56'h123456789ABCDE;
    localparam logic [55:0] FC = 56'hF0E1D2C3B4A596;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rgbw_spi_frame_tx_if a ();
    rgbw_spi_frame_tx_if b ();

    rgbw_spi_frame_tx #(.CLK_DIV(2), .GAP_CYC(G)) d2 (.clk(clk), .reset(reset), .io(a.slave));
    rgbw_spi_frame_tx #(.CLK_DIV(1), .GAP_CYC(G)) d1 (.clk(clk), .reset(reset), .io(b.slave));

    int checks = 0;
    int errors = 0;

    logic [4:0]  out_v [2];
    logic        st    [2];
    logic [55:0] byt   [2];
    assign out_v[0] = {a.cs, a.sck, a.mosi, a.busy, a.done};
    assign out_v[1] = {b.cs, b.sck, b.mosi, b.busy, b.done};
    assign st[0]    = a.start;
    assign st[1]    = b.start;
    assign byt[0]   = {a.mode_in, a.lint_in, a.color_idx_in, a.red_in, a.green_in, a.blue_in, a.white_in};
    assign byt[1]   = {b.mode_in, b.lint_in, b.color_idx_in, b.red_in, b.green_in, b.blue_in, b.white_in};

    function automatic int div_of(input int j);
        return (j == 0) ? 2 : 1;
    endfunction

    function automatic int len_of(input int j);
        return 113 * div_of(j) + G + 1;
    endfunction

    // Expected {cs,sck,mosi,busy,done} t cycles after the accept edge: phase p alternates low/high, bit p/2 on mosi.
    function automatic logic [4:0] exp_out(input int t, input int d, input logic [55:0] f);
        int p;
        if (t == 0) return 5'b10000;
        if (t <= 113 * d) begin
            p = (t - 1) / d;
            return {1'b0, p[0], (p < 112) ? f[55 - p / 2] : 1'b0, 1'b1, 1'b0};
        end
        if (t <= 113 * d + G) return 5'b10010;
        return 5'b10001;
    endfunction

    int          t  [2] = '{0, 0};
    logic [55:0] fd [2];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (reset) t[j] = 0;
            else if ((t[j] == 0 || t[j] == len_of(j)) && st[j]) begin
                t[j]  = 1;
                fd[j] = byt[j];
            end else if (t[j] == len_of(j)) t[j] = 0;
            else if (t[j] != 0) t[j] = t[j] + 1;
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            checks = checks + 1;
            if (out_v[j] !== exp_out(t[j], div_of(j), fd[j])) begin
                errors = errors + 1;
                $display("FAIL cycle_model dut%0d t=%0d got=%b exp=%b", j, t[j], out_v[j],
                         exp_out(t[j], div_of(j), fd[j]));
            end
        end
    end

    logic        pck [2] = '{1'b0, 1'b0};
    logic        pcs [2] = '{1'b1, 1'b1};
    logic [55:0] rx [2], last_rx [2];
    int nb [2] = '{0, 0};
    int lowc [2] = '{0, 0};
    int highc [2] = '{0, 0};
    int last_nb [2], last_low [2], last_gap [2], last_lat [2], fall_cyc [2];
    int done_cnt [2] = '{0, 0};
    int mcyc = 0;

    // Deserializer: collects mosi on sck rising edges and measures cs windows and done latency.
    always @(posedge clk) begin
        #1;
        mcyc = mcyc + 1;
        for (int j = 0; j < 2; j++) begin
            if (pcs[j] && !out_v[j][4]) begin
                rx[j]       = '0;
                nb[j]       = 0;
                lowc[j]     = 0;
                fall_cyc[j] = mcyc;
                last_gap[j] = highc[j];
            end
            if (!pcs[j] && out_v[j][4]) begin
                last_rx[j]  = rx[j];
                last_nb[j]  = nb[j];
                last_low[j] = lowc[j];
                highc[j]    = 0;
            end
            if (!out_v[j][4]) lowc[j] = lowc[j] + 1;
            else highc[j] = highc[j] + 1;
            if (!pck[j] && out_v[j][3] && !out_v[j][4]) begin
                rx[j] = {rx[j][54:0], out_v[j][2]};
                nb[j] = nb[j] + 1;
            end
            if (out_v[j][0]) begin
                done_cnt[j] = done_cnt[j] + 1;
                last_lat[j] = mcyc - fall_cyc[j] + 1;
            end
            pck[j] = out_v[j][3];
            pcs[j] = out_v[j][4];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic set_bytes(input logic [55:0] v);
        {a.mode_in, a.lint_in, a.color_idx_in, a.red_in, a.green_in, a.blue_in, a.white_in} = v;
        {b.mode_in, b.lint_in, b.color_idx_in, b.red_in, b.green_in, b.blue_in, b.white_in} = v;
    endtask

    task automatic wait_done(input int j, input int n0, input int lim);
        int k = 0;
        while (done_cnt[j] <= n0 && k < lim) begin
            @(negedge clk);
            k = k + 1;
        end
        chk($sformatf("done_timeout_dut%0d", j), 64'(done_cnt[j] > n0), 64'd1);
    endtask

    initial begin
        int n, k;
        a.start = 1'b1;
        b.start = 1'b1;
        set_bytes(56'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs_dut0", 64'(out_v[0]), 64'b10000);
        chk("reset_outs_dut1", 64'(out_v[1]), 64'b10000);
        reset   = 1'b0;
        a.start = 1'b0;
        b.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outs_dut0", 64'(out_v[0]), 64'b10000);

        n = done_cnt[0];
        set_bytes(FA);
        a.start = 1'b1;
        b.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        b.start = 1'b0;
        wait_done(0, n, 400);
        chk("latency_dut0", 64'(last_lat[0]), 64'd231);
        chk("cs_low_dut0", 64'(last_low[0]), 64'd226);
        chk("bits_dut0", 64'(last_nb[0]), 64'd56);
        chk("data_dut0", 64'(last_rx[0]), 64'(FA));
        chk("latency_dut1", 64'(last_lat[1]), 64'd118);
        chk("cs_low_dut1", 64'(last_low[1]), 64'd113);
        chk("data_dut1", 64'(last_rx[1]), 64'(FA));

        n = done_cnt[0];
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        repeat (100) @(negedge clk);
        set_bytes(FB);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        set_bytes(56'h0);
        wait_done(0, n, 400);
        chk("busy_ignore_data", 64'(last_rx[0]), 64'(FA));
        repeat (300) @(negedge clk);
        chk("busy_ignore_no_second", 64'(done_cnt[0]), 64'(n + 1));

        n = done_cnt[1];
        set_bytes(FB);
        b.start = 1'b1;
        wait_done(1, n, 200);
        chk("b2b_first_data", 64'(last_rx[1]), 64'(FB));
        set_bytes(FC);
        @(negedge clk);
        b.start = 1'b0;
        wait_done(1, n + 1, 200);
        chk("b2b_second_data", 64'(last_rx[1]), 64'(FC));
        chk("b2b_cs_gap", 64'(last_gap[1]), 64'(G + 1));
        repeat (50) @(negedge clk);
        chk("b2b_no_third", 64'(done_cnt[1]), 64'(n + 2));

        n = done_cnt[0];
        set_bytes(FA);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        k = 0;
        while (nb[0] < 20 && k < 200) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("mid_reach_20_edges", 64'(nb[0]), 64'd20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_outs", 64'({a.cs, a.sck, a.mosi, a.busy, a.done}), 64'b10000);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_reset_no_done", 64'(done_cnt[0]), 64'(n));
        set_bytes(FB);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        wait_done(0, n, 400);
        chk("after_reset_data", 64'(last_rx[0]), 64'(FB));
        chk("after_reset_bits", 64'(last_nb[0]), 64'd56);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rgbw_spi_frame_tx.md
Name: rgbw_spi_frame_tx

Overview:
- Host-side SPI master that sends one complete lamp configuration frame to the lamp's SPI receiver pins (sck, cs, mosi).
- Latches seven configuration bytes on a start strobe and shifts them out serially. SPI mode 0, MSB first, one frame per cs-low window.
- Used in the bench harness and in host/bridge designs that drive the lamp controller.

Parameters:
- CLK_DIV, 2: clk cycles per sck half-period. Legal range 1..255.
- GAP_CYC, 4: clk cycles cs stays high after a frame before the next start is accepted. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- mode_in  in  8  frame byte 0
- lint_in  in  8  frame byte 1 (intensity)
- color_idx_in  in  8  frame byte 2
- red_in  in  8  frame byte 3
- green_in  in  8  frame byte 4
- blue_in  in  8  frame byte 5
- white_in  in  8  frame byte 6
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE after a full frame
- sck  out  1  SPI clock; idles low
- cs  out  1  chip select, active low; idles high
- mosi  out  1  serial data; idles low

Behaviour:
- Reset values: sck=0, cs=1, mosi=0, busy=0, done=0. State is IDLE and all counters are cleared.
- Reset mid-frame: on the next clock the outputs take their reset values and the frame is abandoned. done is not pulsed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States:
  - IDLE: start=1 at edge k latches all seven bytes into a 56-bit shift register (mode in bits 55:48 … white in bits 7:0). At k+1: cs=0, mosi=bit55, busy=1, state=SETUP.
  - SETUP: lasts CLK_DIV cycles, then sck=1 and state=SCK_HI.
  - SCK_HI: lasts CLK_DIV cycles.
    - If bits remain: sck=0, shift left by one so mosi presents the next bit, state=SCK_LO.
    - After the 56th bit: sck=0, mosi=0, state=HOLD.
  - SCK_LO: lasts CLK_DIV cycles, then sck=1 and state=SCK_HI.
  - HOLD: lasts CLK_DIV cycles, then cs=1 and state=GAP.
  - GAP: lasts GAP_CYC cycles, then state=IDLE, busy=0, done=1 for exactly that one cycle.
- mosi changes only on sck falling edges, or at cs assertion for the first bit. It is stable throughout every sck-high phase; the receiver samples on the rising edge.
- Exactly 56 sck rising edges per frame. The bit counter is 6 bits wide and counts 0..55 with no wrap.
- cs low duration is exactly (2 + 2*56 - 1)*CLK_DIV = 113*CLK_DIV cycles:
  - SETUP: CLK_DIV
  - 56 high phases and 55 low phases: 111*CLK_DIV
  - HOLD: CLK_DIV
- Total latency from start-accept edge to done: 113*CLK_DIV + GAP_CYC + 1 cycles.
- start while busy is ignored; it is not queued. Byte input changes during a frame have no effect.
- start held high continuously: a new frame starts on the first IDLE cycle, i.e. the cycle done is high. busy rises the next cycle.
- start and reset in the same cycle: reset wins.

Test Plan:
- Reset check: assert reset for 3 cycles with start=1 -> cs=1, sck=0, mosi=0, busy=0, done=0 throughout and after release, until start is sampled in IDLE.
- Single frame, CLK_DIV=2, GAP_CYC=4. Bytes mode=0x01, lint=0xFF, idx=0x00, r=0xA5, g=0x5A, b=0x3C, w=0x81.
  - Monitor samples mosi on sck rising edges -> 56 bits equal to 0x01FF00A55A3C81.
  - cs low for 226 cycles; done rises 231 cycles after the start edge.
- Start ignored while busy: pulse start mid-frame with different bytes -> the in-flight frame is unchanged and no second frame follows.
- Back-to-back: hold start high for two frames with CLK_DIV=1 -> cs high for exactly GAP_CYC+1 cycles between frames; both frames decode correctly.
- Reset mid-frame: assert reset after 20 sck edges -> next cycle cs=1, sck=0; done never pulses. A subsequent frame transmits correctly.
- Loopback: connect to the lamp SPI receiver and deserializer; send the frame above -> the deserializer's seven byte outputs match the transmitted values.
